// File: rtl/simd_seq_pkg.sv
// -----------------------------------------------------------------------------
// simd_seq_pkg
// Shared definitions for the SIMD job sequencer:
//   - bus width constants (opcode, beat count, operand data)
//   - opcode encodings shared with simd_top_level
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package simd_seq_pkg;

  localparam int OPCODE_W = 3;
  localparam int SIZE_W   = 6;
  localparam int DATA_W   = 128;

  // Opcodes understood by the simd_top_level processors.
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_MUL = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_MAC = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/simd_seq_beat_cnt.sv
// -----------------------------------------------------------------------------
// simd_seq_beat_cnt
// Loadable beat counter with limit comparator for the job sequencer.
//
// Ports:
//   clk    in   clock, posedge
//   reset  in   synchronous active-low reset (count -> 0)
//   clear  in   zero the count (new job accepted)
//   incr   in   one operand beat accepted this cycle
//   limit  in   number of beats in the current job (never 0 while counting)
//   below  out  count < limit: more beats may still be accepted
//   last   out  the beat accepted next is the final beat of the job
// -----------------------------------------------------------------------------
module simd_seq_beat_cnt
  import simd_seq_pkg::*;
#(
  parameter int CNT_W = SIZE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] limit,
  output logic             below,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (incr) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // limit is at most 2^CNT_W-1, so the count never wraps and limit-1 never
  // underflows while a job is streaming (zero-size jobs never get here).
  assign below = (cnt_q < limit);
  assign last  = (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/simd_job_sequencer.sv
// -----------------------------------------------------------------------------
// simd_job_sequencer
// Accepts a job descriptor (opcode + beat count) and streams that many operand
// pairs from the memory-controller source into simd_top_level, then waits a
// fixed drain period and pulses done.
//
// Ports:
//   clk, reset             clock (posedge) and synchronous active-low reset
//   job_valid/job_ready    job descriptor handshake
//   job_instr, job_size    job opcode and beat count (0 is rejected)
//   src_valid/src_ready    operand beat handshake
//   src_opa, src_opb       operand beat
//   valid_instruction      opcode/size valid to datapath (CONFIG and STREAM)
//   instruction, data_size latched job descriptor to datapath
//   valid_data             registered beat valid to datapath
//   mc_data_in_opa/opb     registered operand data to datapath
//   busy                   job in flight (FSM not IDLE)
//   done                   one-cycle completion pulse
//   err_size               one-cycle pulse when a zero-size job is rejected
// -----------------------------------------------------------------------------
module simd_job_sequencer
  import simd_seq_pkg::*;
#(
  parameter int DATA_W       = simd_seq_pkg::DATA_W,
  parameter int SIZE_W       = simd_seq_pkg::SIZE_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [OPCODE_W-1:0] job_instr,
  input  logic [SIZE_W-1:0]   job_size,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_W-1:0]   src_opa,
  input  logic [DATA_W-1:0]   src_opb,
  output logic                valid_instruction,
  output logic [OPCODE_W-1:0] instruction,
  output logic [SIZE_W-1:0]   data_size,
  output logic                valid_data,
  output logic [DATA_W-1:0]   mc_data_in_opa,
  output logic [DATA_W-1:0]   mc_data_in_opb,
  output logic                busy,
  output logic                done,
  output logic                err_size
);

  localparam int DRAIN_W = 4;

  seq_state_t          state_q;
  seq_state_t          state_d;

  logic                job_ready_q;
  logic                err_size_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [OPCODE_W-1:0] instr_q;
  logic [SIZE_W-1:0]   size_q;

  logic                vld_p1;
  logic [DATA_W-1:0]   opa_p1;
  logic [DATA_W-1:0]   opb_p1;

  logic                job_fire;
  logic                job_zero;
  logic                beat_fire;
  logic                beat_below;
  logic                beat_last;
  logic                stream_ready;
  logic                drain_enter;

  // job_ready is a register, so it is only ever high while the FSM is in IDLE
  // and stays low through the first cycle after reset is released.
  assign job_fire    = job_valid & job_ready_q;
  assign job_zero    = (job_size == '0);
  assign beat_fire   = src_valid & stream_ready;
  assign drain_enter = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);

  simd_seq_beat_cnt #(
    .CNT_W (SIZE_W)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (job_fire),
    .incr  (beat_fire),
    .limit (size_q),
    .below (beat_below),
    .last  (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    stream_ready      = 1'b0;
    valid_instruction = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (job_fire && !job_zero) begin
          state_d = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        valid_instruction = 1'b1;
        state_d           = ST_STREAM;
      end
      ST_STREAM: begin
        valid_instruction = 1'b1;
        // Depends only on registered state, never on src_valid.
        stream_ready      = beat_below;
        if (src_valid && beat_below && beat_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers: handshake ready, error pulse, drain timer, descriptor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      job_ready_q <= 1'b0;
      err_size_q  <= 1'b0;
      drain_q     <= '0;
      instr_q     <= '0;
      size_q      <= '0;
    end else begin
      job_ready_q <= (state_d == ST_IDLE);
      err_size_q  <= job_fire & job_zero;
      if (drain_enter) begin
        drain_q <= DRAIN_W'(DRAIN_CYCLES);
      end else if (state_q == ST_DRAIN) begin
        drain_q <= drain_q - 1'b1;
      end
      // Zero-size jobs are consumed but leave the previous descriptor intact.
      if (job_fire && !job_zero) begin
        instr_q <= job_instr;
        size_q  <= job_size;
      end
    end
  end

  // ---- stage p0 -> p1: accepted source beat registered toward the datapath ----
  // Data holds its last value across bubbles; only vld_p1 drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      opa_p1 <= '0;
      opb_p1 <= '0;
    end else begin
      vld_p1 <= beat_fire;
      if (beat_fire) begin
        opa_p1 <= src_opa;
        opb_p1 <= src_opb;
      end
    end
  end

  assign job_ready      = job_ready_q;
  assign src_ready      = stream_ready;
  assign err_size       = err_size_q;
  assign instruction    = instr_q;
  assign data_size      = size_q;
  assign valid_data     = vld_p1;
  assign mc_data_in_opa = opa_p1;
  assign mc_data_in_opb = opb_p1;

endmodule

// File: tb/tb_simd_job_sequencer.sv
module tb_simd_job_sequencer;

  localparam int DATA_W = 128;
  localparam int SIZE_W = 6;
  localparam int DRAIN  = 4;
  localparam logic [127:0] BASE_A = 128'h11111111_22222222_55555555_66666666;
  localparam logic [127:0] BASE_B = 128'h11111111_22222222_33333333_44444444;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [2:0]        job_instr = '0;
  logic [SIZE_W-1:0] job_size = '0;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic [DATA_W-1:0] src_opa = '0;
  logic [DATA_W-1:0] src_opb = '0;
  logic              valid_instruction;
  logic [2:0]        instruction;
  logic [SIZE_W-1:0] data_size;
  logic              valid_data;
  logic [DATA_W-1:0] mc_data_in_opa;
  logic [DATA_W-1:0] mc_data_in_opb;
  logic              busy;
  logic              done;
  logic              err_size;

  always #5 clk = ~clk;

  simd_job_sequencer #(
    .DATA_W       (DATA_W),
    .SIZE_W       (SIZE_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_instr         (job_instr),
    .job_size          (job_size),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_opa           (src_opa),
    .src_opb           (src_opb),
    .valid_instruction (valid_instruction),
    .instruction       (instruction),
    .data_size         (data_size),
    .valid_data        (valid_data),
    .mc_data_in_opa    (mc_data_in_opa),
    .mc_data_in_opb    (mc_data_in_opb),
    .busy              (busy),
    .done              (done),
    .err_size          (err_size)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard and event monitor, sampled on the falling edge.
  logic [255:0] sb_q[$];
  logic [255:0] hold_data = '0;
  logic [255:0] exp_d;
  logic [255:0] got_d;
  logic         prev_fire = 1'b0;
  bit           first_vd_armed = 1'b0;
  int           accept_cyc = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  int           fwd_cnt = 0;
  int           first_vd_cyc = 0;
  int           last_vd_cyc = 0;
  int           last_fire_cyc = 0;

  always @(negedge clk) begin
    got_d = {mc_data_in_opa, mc_data_in_opb};
    chk("vd_follow", valid_data, prev_fire);
    if (valid_data) begin
      fwd_cnt++;
      last_vd_cyc = cyc;
      if (first_vd_armed) begin
        first_vd_cyc   = cyc;
        first_vd_armed = 1'b0;
      end
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_d = sb_q.pop_front();
        chk("beat_data", got_d, exp_d);
        hold_data = exp_d;
      end
    end else begin
      chk("hold_data", got_d, hold_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_lat", cyc, last_fire_cyc + DRAIN + 1);
    end
    if (err_size) err_cnt++;
    prev_fire = reset && src_valid && src_ready;
    if (prev_fire) begin
      sb_q.push_back({src_opa, src_opb});
      last_fire_cyc = cyc;
    end
    if (reset && job_valid && job_ready) begin
      accept_cyc     = cyc;
      first_vd_armed = 1'b1;
    end
    if (!reset) begin
      hold_data = '0;
      sb_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_valid_instr", valid_instruction, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_data_size", data_size, 0);
    chk("rst_valid_data", valid_data, 0);
    chk("rst_opa", mc_data_in_opa, 0);
    chk("rst_opb", mc_data_in_opb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_size", err_size, 0);
  endtask

  task automatic send_job(input logic [2:0] instr, input logic [SIZE_W-1:0] size);
    bit got;
    got = 1'b0;
    job_instr = instr;
    job_size  = size;
    job_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (job_ready) got = 1'b1;
      tick();
    end
    job_valid = 1'b0;
    chk("job_accept", got, 1);
  endtask

  task automatic run_src(input int n, input bit bubbles, input int budget);
    int idx;
    bit tog;
    bit acc;
    idx = 0;
    tog = 1'b1;
    for (int c = 0; c < budget && idx < n; c++) begin
      src_valid = bubbles ? tog : 1'b1;
      src_opa   = BASE_A + 128'(idx);
      src_opb   = BASE_B + 128'(idx);
      @(negedge clk);
      acc = src_valid && src_ready;
      tick();
      if (acc) idx++;
      tog = ~tog;
    end
    src_valid = 1'b0;
    chk("src_beats", idx, n);
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("ready_at_done", job_ready, 0);
      @(negedge clk);
      chk("ready_after_done", job_ready, 1);
      chk("idle_after_done", busy, 0);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn0;
    int sec_cyc;
    bit got;

    // Reset state and release timing.
    tick(); tick(); tick();
    @(negedge clk);
    chk_all_zero();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("ready_release_cycle", job_ready, 0);
    @(negedge clk);
    chk("ready_after_release", job_ready, 1);
    tick();

    // Basic 13-beat job.
    fwd_cnt = 0;
    fork
      send_job(3'b101, 6'd13);
      run_src(13, 1'b0, 100);
    join
    wait_done(50);
    chk("basic_first_vd", first_vd_cyc, accept_cyc + 3);
    chk("basic_vd_run", last_vd_cyc - first_vd_cyc, 12);
    chk("basic_fwd", fwd_cnt, 13);
    chk("basic_instr", instruction, 3'b101);
    chk("basic_size", data_size, 13);

    // Bubbles: valid 1,0,1,0,1,0,1.
    fwd_cnt = 0;
    send_job(3'b011, 6'd4);
    tick();
    run_src(4, 1'b1, 20);
    wait_done(50);
    chk("bubble_fwd", fwd_cnt, 4);
    chk("bubble_span", last_vd_cyc - first_vd_cyc, 6);
    chk("bubble_first_vd", first_vd_cyc, accept_cyc + 3);

    // Zero-size job is rejected.
    send_job(3'b010, 6'd0);
    @(negedge clk);
    chk("zero_err", err_size, 1);
    chk("zero_busy", busy, 0);
    chk("zero_vi", valid_instruction, 0);
    chk("zero_ready", job_ready, 1);
    chk("zero_instr_kept", instruction, 3'b011);
    chk("zero_size_kept", data_size, 4);
    @(negedge clk);
    chk("zero_err_pulse", err_size, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_vi2", valid_instruction, 0);
    tick();

    // Max size 63, then a 64th beat offered must not be taken.
    fwd_cnt = 0;
    fork
      send_job(3'b001, 6'd63);
      run_src(63, 1'b0, 200);
    join
    src_valid = 1'b1;
    src_opa   = '1;
    src_opb   = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("max_no_ready", src_ready, 0);
      tick();
    end
    src_valid = 1'b0;
    wait_done(50);
    chk("max_fwd", fwd_cnt, 63);
    chk("max_size", data_size, 63);

    // Reset after 5 of 13 beats.
    fwd_cnt = 0;
    dn0 = done_cnt;
    fork
      send_job(3'b111, 6'd13);
      run_src(5, 1'b0, 50);
    join
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready_release", job_ready, 0);
    @(negedge clk);
    chk("mid_ready_after", job_ready, 1);
    chk("mid_no_done", done_cnt, dn0);
    chk("mid_fwd", fwd_cnt, 5);
    tick();
    fwd_cnt = 0;
    fork
      send_job(3'b100, 6'd3);
      run_src(3, 1'b0, 50);
    join
    wait_done(50);
    chk("fresh_fwd", fwd_cnt, 3);
    chk("fresh_instr", instruction, 3'b100);
    chk("fresh_size", data_size, 3);

    // Back-to-back jobs with job_valid held.
    fwd_cnt = 0;
    sec_cyc = 0;
    fork
      begin
        got = 1'b0;
        job_instr = 3'b001;
        job_size  = 6'd2;
        job_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          if (job_ready) got = 1'b1;
          tick();
        end
        chk("b2b_first_accept", got, 1);
        job_instr = 3'b110;
        job_size  = 6'd3;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
          @(negedge clk);
          if (job_ready) begin
            got     = 1'b1;
            sec_cyc = cyc;
          end else begin
            chk("b2b_instr_hold", instruction, 3'b001);
            chk("b2b_size_hold", data_size, 2);
          end
          tick();
        end
        job_valid = 1'b0;
        chk("b2b_second_accept", got, 1);
        chk("b2b_after_done", sec_cyc, done_cyc + 1);
      end
      run_src(5, 1'b0, 100);
    join
    wait_done(50);
    chk("b2b_fwd", fwd_cnt, 5);
    chk("b2b_instr", instruction, 3'b110);
    chk("b2b_size", data_size, 3);
    chk("b2b_err_none", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simd_job_sequencer.md
# simd_job_sequencer

Sequences jobs onto the `simd_top_level` datapath. It accepts a job descriptor (opcode plus beat count) over a valid/ready handshake, then streams exactly that many 128-bit operand pairs from a memory-controller source into the datapath. It drives `valid_instruction`, `instruction`, `data_size`, `valid_data` and `mc_data_in_opa/opb` in the required order, waits a fixed drain period for the processors to finish, and reports completion. It sits between the job/memory side and the `simd_top_level` instance.

## Interface
- `DATA_W`, 128, operand width per operand bus
- `SIZE_W`, 6, width of the beat count (`data_size`)
- `DRAIN_CYCLES`, 4, cycles between the last data beat and `done`; legal range 1..15
- `clk`  in  1  single clock; all logic is posedge
- `reset`  in  1  reset; one clock; reset is synchronous and active-low
- `job_valid`  in  1  job descriptor valid
- `job_ready`  out  1  sequencer can accept a job
- `job_instr`  in  3  opcode for the job
- `job_size`  in  SIZE_W  number of operand beats; 0 is illegal
- `src_valid`  in  1  operand beat valid
- `src_ready`  out  1  sequencer accepts an operand beat
- `src_opa`, `src_opb`  in  DATA_W  operand beat
- `valid_instruction`  out  1  to datapath
- `instruction`  out  3  to datapath
- `data_size`  out  SIZE_W  to datapath
- `valid_data`  out  1  to datapath
- `mc_data_in_opa`, `mc_data_in_opb`  out  DATA_W  to datapath
- `busy`  out  1  a job is in flight (any state other than IDLE)
- `done`  out  1  one-cycle pulse when a job completes
- `err_size`  out  1  one-cycle pulse when a zero-size job is rejected

## Operation
- The FSM has five states: IDLE, CONFIG, STREAM, DRAIN, DONE.
- IDLE: `job_ready`=1. On `job_valid & job_ready`:
  - If `job_size`=0: the job is consumed, `err_size` pulses next cycle, and the FSM stays in IDLE.
  - Otherwise: latch `job_instr` into `instruction` and `job_size` into `data_size`, clear the beat counter, and go to CONFIG.
- CONFIG (1 cycle): `valid_instruction`=1 and `src_ready`=0. Go to STREAM.
- STREAM:
  - `valid_instruction`=1.
  - `src_ready`=1 while `beat_cnt < data_size`.
  - Each `src_valid & src_ready` registers `src_opa/opb` to `mc_data_in_opa/opb`, sets `valid_data`=1 on the next cycle, and increments `beat_cnt`.
  - A cycle with no accepted beat produces `valid_data`=0 on the next cycle. The datapath treats this as a bubble. Output data holds its last value during bubbles.
  - Accepting beat number `data_size` moves the FSM to DRAIN.
- DRAIN: `valid_instruction`=0 and `src_ready`=0. The drain counter is loaded with `DRAIN_CYCLES` on entry and decremented each cycle. At 1, go to DONE.
- DONE (1 cycle): `done`=1. Go to IDLE.
- `instruction` and `data_size` hold stable from CONFIG until the next accepted job. They are never changed mid-job.
- `beat_cnt` is SIZE_W bits wide. The maximum job is 2^SIZE_W−1 = 63 beats, so no wrap can occur.
- `job_valid` is ignored outside IDLE. A new job cannot be accepted in the same cycle as `done`.

## Timing
- All outputs reset to 0, including `job_ready`, the data buses, `instruction` and `data_size`. The FSM resets to IDLE, and `job_ready` rises the cycle after reset deasserts.
- Job accepted in cycle T: CONFIG is T+1 and the first possible beat acceptance is T+2.
- Beat accepted in cycle S: `valid_data` and its data appear in cycle S+1.
- Last beat accepted in cycle L:
  - `valid_data`=1 in L+1; DRAIN runs L+1 .. L+DRAIN_CYCLES.
  - `done` is asserted in L+DRAIN_CYCLES+1.
  - `job_ready`=1 again in L+DRAIN_CYCLES+2.
- Minimum job occupancy with no bubbles is 3 + size + DRAIN_CYCLES cycles.
- Reset asserted in any state: the next edge returns the FSM to IDLE and zeroes all outputs. A partial job is discarded and no `done` is issued.
- The source handshake is standard: `src_ready` does not depend combinationally on `src_valid`.

## Structure
- Package `simd_seq_pkg` holds:
  - the FSM state enum (IDLE, CONFIG, STREAM, DRAIN, DONE);
  - the `OPCODE_W`=3, `SIZE_W`=6 and `DATA_W`=128 constants;
  - the opcode localparams shared with `simd_top_level`.
- Sub-module `simd_seq_beat_cnt` contains the loadable beat counter and comparator. It takes clear, increment and limit inputs and produces a `last` flag. The drain counter stays inline.

## Test plan
- Basic job: `job_instr`=3'b101, `job_size`=13, 13 back-to-back beats, starting with opa=128'h11111111_22222222_55555555_66666666 and opb=128'h11111111_22222222_33333333_44444444.
  - Expect `valid_data` high for 13 consecutive cycles starting 3 cycles after job acceptance, data in order, and `done` exactly DRAIN_CYCLES+1 cycles after the last beat is accepted.
- Bubbles: `job_size`=4 with `src_valid` toggling 1,0,1,0,1,0,1.
  - Expect `valid_data` pattern 1,0,1,0,1,0,1 one cycle later, held data during gaps, and exactly 4 beats forwarded.
- Zero size: `job_size`=0.
  - Expect an `err_size` pulse the next cycle, `busy` staying 0 and no `valid_instruction`.
- Max size: `job_size`=63.
  - Expect exactly 63 beats, then `src_ready`=0 even with `src_valid` held at 1, and a 64th beat not consumed.
- Reset mid-stream: assert `reset`=0 after 5 of 13 beats.
  - Expect all outputs 0 on the next edge, no `done`, `job_ready`=1 after release, and a fresh job running correctly.
- Back-to-back jobs: `job_valid` held with sizes 2 then 3.
  - Expect the second job accepted only in the cycle after DONE, and `instruction`/`data_size` unchanged until then.
